// File: rtl/pipe_pkg.sv
// Shared pipeline constants: exception codes, occupancy encodings and IF/ID payload layout.
package pipe_pkg;

  localparam int unsigned EXC_W_DEF = 4;

  localparam logic [EXC_W_DEF-1:0] EXC_INSTR_MISALIGN = 4'h0;
  localparam logic [EXC_W_DEF-1:0] EXC_INSTR_FAULT    = 4'h1;
  localparam logic [EXC_W_DEF-1:0] EXC_ILLEGAL_INSTR  = 4'h2;
  localparam logic [EXC_W_DEF-1:0] EXC_NONE           = 4'hF;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // IF/ID payload: {instr, pc, pc+4}, 32 bits each
  localparam int unsigned FIELD_W   = 32;
  localparam int unsigned INSTR_LSB = 64;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned PC_P4_LSB = 0;
  localparam int unsigned IF_ID_W   = 96;

  function automatic logic [IF_ID_W-1:0] pack_if_id(input logic [FIELD_W-1:0] instr,
                                                    input logic [FIELD_W-1:0] pc);
    logic [IF_ID_W-1:0] word;
    word = '0;
    word[INSTR_LSB +: FIELD_W] = instr;
    word[PC_LSB    +: FIELD_W] = pc;
    word[PC_P4_LSB +: FIELD_W] = pc + 32'd4;
    return word;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid/data/exc register slot with synchronous clear (priority) and load.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W   = 96,
  parameter int unsigned          EXC_W    = 4,
  parameter logic [EXC_W-1:0]     EXC_NONE = EXC_W'(pipe_pkg::EXC_NONE)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [EXC_W-1:0]  i_exc,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [EXC_W-1:0]  o_exc
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [EXC_W-1:0]  exc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      exc_q   <= EXC_NONE;
    end else if (i_load) begin
      valid_q <= 1'b1;
      data_q  <= i_data;
      exc_q   <= i_exc;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_exc   = exc_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic inter-stage register: 2-entry skid buffer with registered upstream ready.
// Optional perf counters enabled by defining PIPE_SKID_STAGE_PERF_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      DATA_W         = 96,
  parameter int unsigned      EXC_W          = 4,
  parameter logic [EXC_W-1:0] EXC_NONE       = EXC_W'(pipe_pkg::EXC_NONE),
  parameter bit               ZERO_ON_BUBBLE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_flush,
  input  logic              i_flush_exc,
  input  logic              i_valid_up,
  output logic              o_ready_up,
  input  logic [DATA_W-1:0] i_data_up,
  input  logic [EXC_W-1:0]  i_exc_up,
  output logic              o_valid_dn,
  input  logic              i_ready_dn,
  output logic [DATA_W-1:0] o_data_dn,
  output logic [EXC_W-1:0]  o_exc_dn,
  output logic [1:0]        o_occupancy
`ifdef PIPE_SKID_STAGE_PERF_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  occ_e              occ_q;
  logic              flush;
  logic              acc;
  logic              pop;
  logic [DATA_W-1:0] up_data;

  logic              head_valid, head_load, head_clr;
  logic [DATA_W-1:0] head_data, head_data_in;
  logic [EXC_W-1:0]  head_exc, head_exc_in;
  logic              skid_valid, skid_load, skid_clr;
  logic [DATA_W-1:0] skid_data;
  logic [EXC_W-1:0]  skid_exc;

  assign flush = i_flush | i_flush_exc;
  assign acc   = i_clk_en & i_valid_up & ~skid_valid;
  assign pop   = i_clk_en & head_valid & i_ready_dn;

  // Faulting beats travel as tagged NOPs: payload dropped, code kept
  assign up_data = (i_exc_up != EXC_NONE) ? '0 : i_data_up;

  // Skid is only ever occupied while upstream is blocked, so acc and a skid refill never coincide
  assign head_load    = (acc & (~head_valid | pop)) | (skid_valid & pop);
  assign head_clr     = flush | (pop & ~acc & ~skid_valid);
  assign head_data_in = skid_valid ? skid_data : up_data;
  assign head_exc_in  = skid_valid ? skid_exc : i_exc_up;
  assign skid_load    = acc & head_valid & ~pop;
  assign skid_clr     = flush | (skid_valid & pop);

  pipe_skid_entry #(
    .DATA_W   (DATA_W),
    .EXC_W    (EXC_W),
    .EXC_NONE (EXC_NONE)
  ) u_head (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (head_clr),
    .i_load  (head_load),
    .i_data  (head_data_in),
    .i_exc   (head_exc_in),
    .o_valid (head_valid),
    .o_data  (head_data),
    .o_exc   (head_exc)
  );

  pipe_skid_entry #(
    .DATA_W   (DATA_W),
    .EXC_W    (EXC_W),
    .EXC_NONE (EXC_NONE)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (skid_clr),
    .i_load  (skid_load),
    .i_data  (up_data),
    .i_exc   (i_exc_up),
    .o_valid (skid_valid),
    .o_data  (skid_data),
    .o_exc   (skid_exc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      occ_q <= OCC_EMPTY;
    end else if (i_clk_en) begin
      unique case (occ_q)
        OCC_EMPTY: if (acc) occ_q <= OCC_ONE;
        OCC_ONE: begin
          if (acc && !pop)      occ_q <= OCC_FULL;
          else if (!acc && pop) occ_q <= OCC_EMPTY;
        end
        OCC_FULL:  if (pop) occ_q <= OCC_ONE;
        default:   occ_q <= OCC_EMPTY;
      endcase
    end
  end

  assign o_occupancy = occ_q;
  assign o_ready_up  = ~skid_valid;
  assign o_valid_dn  = head_valid;

  always_comb begin
    o_data_dn = head_data;
    o_exc_dn  = head_exc;
    if (ZERO_ON_BUBBLE && !head_valid) begin
      o_data_dn = '0;
      o_exc_dn  = EXC_NONE;
    end
  end

`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (i_clk_en && head_valid && !i_ready_dn && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (occ_q != OCC_EMPTY) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed steps then random traffic against a queue-based model.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 96;
  localparam int unsigned EW = 4;
  localparam logic [3:0]  XNONE = 4'hF;

  logic          clk = 1'b0;
  logic          rst, clk_en, flush, flush_exc, valid_up, ready_dn;
  logic [DW-1:0] data_up;
  logic [EW-1:0] exc_up;
  logic          ready_up, valid_dn;
  logic [DW-1:0] data_dn;
  logic [EW-1:0] exc_dn;
  logic [1:0]    occupancy;
`ifdef PIPE_SKID_STAGE_PERF_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_flush     (flush),
    .i_flush_exc (flush_exc),
    .i_valid_up  (valid_up),
    .o_ready_up  (ready_up),
    .i_data_up   (data_up),
    .i_exc_up    (exc_up),
    .o_valid_dn  (valid_dn),
    .i_ready_dn  (ready_dn),
    .o_data_dn   (data_dn),
    .o_exc_dn    (exc_dn),
    .o_occupancy (occupancy)
`ifdef PIPE_SKID_STAGE_PERF_EN
    ,
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] exc;
  } beat_t;

  beat_t       model_q[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    beat_t head;
    head = '{data: '0, exc: XNONE};
    if (model_q.size() > 0) head = model_q[0];
    chk({tag, ".valid"}, 128'(valid_dn), 128'(model_q.size() > 0));
    chk({tag, ".ready"}, 128'(ready_up), 128'(model_q.size() < 2));
    chk({tag, ".occ"}, 128'(occupancy), 128'(model_q.size()));
    chk({tag, ".data"}, 128'(data_dn), 128'(head.data));
    chk({tag, ".exc"}, 128'(exc_dn), 128'(head.exc));
`ifdef PIPE_SKID_STAGE_PERF_EN
    chk({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
    chk({tag, ".flush_cnt"}, 128'(flush_cnt), 128'(m_flush));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic step(input string tag, input logic r, input logic fl, input logic fe,
                      input logic en, input logic vu, input logic [DW-1:0] d,
                      input logic [EW-1:0] e, input logic rd);
    bit    a, p;
    beat_t b;
    rst = r; flush = fl; flush_exc = fe; clk_en = en;
    valid_up = vu; data_up = d; exc_up = e; ready_dn = rd;
    if (r) begin
      model_q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (en && model_q.size() > 0 && !rd && m_stall != 32'hFFFF_FFFF) m_stall++;
      if ((fl || fe) && model_q.size() > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
      if (fl || fe) begin
        model_q.delete();
      end else if (en) begin
        a = vu && (model_q.size() < 2);
        p = (model_q.size() > 0) && rd;
        if (p) void'(model_q.pop_front());
        if (a) begin
          b.data = (e != XNONE) ? '0 : d;
          b.exc  = e;
          model_q.push_back(b);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] rd_data;
    logic [EW-1:0] rd_exc;
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; flush_exc = 1'b0;
    valid_up = 1'b0; data_up = '0; exc_up = XNONE; ready_dn = 1'b0;

    step("reset0", 1, 0, 0, 1, 1, 96'hAAAA, XNONE, 1);
    step("reset1", 1, 0, 0, 1, 1, 96'hBBBB, XNONE, 1);
    chk("reset.valid_const", 128'(valid_dn), 128'(0));
    chk("reset.ready_const", 128'(ready_up), 128'(1));
    chk("reset.exc_const", 128'(exc_dn), 128'(4'hF));
    chk("reset.occ_const", 128'(occupancy), 128'(0));

`ifdef PIPE_SKID_STAGE_PERF_EN
    step("perf_acc", 0, 0, 0, 1, 1, 96'h77, XNONE, 0);
    for (int i = 0; i < 5; i++) step("perf_stall", 0, 0, 0, 1, 0, '0, XNONE, 0);
    step("perf_flush", 0, 1, 0, 0, 0, '0, XNONE, 0);
    chk("perf.stall_const", 128'(stall_cnt), 128'(5));
    chk("perf.flush_const", 128'(flush_cnt), 128'(1));
`endif

    // Streaming at full rate
    step("stream1", 0, 0, 0, 1, 1, 96'd1, XNONE, 1);
    chk("stream1.data_const", 128'(data_dn), 128'(1));
    step("stream2", 0, 0, 0, 1, 1, 96'd2, XNONE, 1);
    step("stream3", 0, 0, 0, 1, 1, 96'd3, XNONE, 1);
    chk("stream3.data_const", 128'(data_dn), 128'(3));
    chk("stream3.occ_const", 128'(occupancy), 128'(1));
    step("stream_drain", 0, 0, 0, 1, 0, '0, XNONE, 1);

    // Backpressure: A, B fill both entries; C must wait upstream
    step("bp_a", 0, 0, 0, 1, 1, 96'hA, XNONE, 0);
    step("bp_b", 0, 0, 0, 1, 1, 96'hB, XNONE, 0);
    chk("bp.occ_const", 128'(occupancy), 128'(2));
    chk("bp.ready_const", 128'(ready_up), 128'(0));
    step("bp_c_held", 0, 0, 0, 1, 1, 96'hC, XNONE, 0);
    step("bp_out_a", 0, 0, 0, 1, 1, 96'hC, XNONE, 1);
    chk("bp.out_b_const", 128'(data_dn), 128'(96'hB));
    step("bp_out_b", 0, 0, 0, 1, 1, 96'hC, XNONE, 1);
    chk("bp.out_c_const", 128'(data_dn), 128'(96'hC));
    step("bp_out_c", 0, 0, 0, 1, 0, '0, XNONE, 1);

    // Exception beat becomes a tagged NOP
    step("exc", 0, 0, 0, 1, 1, 96'h1234, 4'h1, 0);
    chk("exc.data_const", 128'(data_dn), 128'(0));
    chk("exc.code_const", 128'(exc_dn), 128'(4'h1));

    // Clock-enable low holds everything
    step("hold", 0, 0, 0, 0, 1, 96'h55, XNONE, 1);

    // Flush from FULL with clock enable low drops the incoming beat
    step("full_fill", 0, 0, 0, 1, 1, 96'hD, XNONE, 0);
    step("flush", 0, 1, 0, 0, 1, 96'hE, XNONE, 0);
    chk("flush.occ_const", 128'(occupancy), 128'(0));
    step("post_flush", 0, 0, 0, 1, 0, '0, XNONE, 0);
    step("fill_exc_flush", 0, 0, 0, 1, 1, 96'hF0, XNONE, 0);
    step("flush_exc", 0, 0, 1, 1, 1, 96'hF1, XNONE, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rd_data = rand_data();
      rd_exc  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : XNONE;
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7), rd_data, rd_exc, ($urandom_range(0, 9) < 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
